rr_arbiter_4: RTL and testbench

RR_ARBITER_4 -- requirements
Module: rr_arbiter_4

---
 rtl/rr_arbiter_4_pkg.sv | 34 +++
 rtl/mux_4.sv | 24 ++
 rtl/rr_arbiter_4.sv | 81 ++++++++
 tb/tb_rr_arbiter_4.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_4_pkg.sv
// rtl/rr_arbiter_4_pkg.sv - shared constants, state encoding and helpers for rr_arbiter_4
package rr_arbiter_4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // First set request at or after ptr, wrapping; index arithmetic is mod 4 by width.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [IDX_W-1:0]   ptr);
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] result;
    logic             found;
    result = ptr;
    found  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + IDX_W'(k);
      if (!found && req[idx]) begin
        result = idx;
        found  = 1'b1;
      end
    end
    return result;
  endfunction

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/mux_4.sv
// rtl/mux_4.sv - WIDTH-bit 4:1 data multiplexer
module mux_4 #(
  parameter int WIDTH = 32
) (
  output logic [WIDTH-1:0] out,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3
);

  always_comb begin
    out = in0;
    case (select)
      2'd0:    out = in0;
      2'd1:    out = in1;
      2'd2:    out = in2;
      2'd3:    out = in3;
      default: out = in0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - 4-requester round-robin arbiter with valid/ready output handshake
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   in0,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  input  logic [WIDTH-1:0]   in3,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [WIDTH-1:0]   out_data,
  output logic [IDX_W-1:0]   select,
  output logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] ack
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] select_q, select_d;
  logic             busy;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    select_d = select_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          select_d = rr_pick(req, ptr_q);
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // A ready consumer completes the transfer even if the request drops that cycle.
        if (out_ready) begin
          ptr_d   = select_q + IDX_W'(1);
          state_d = ST_IDLE;
        end else if (!req[select_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      select_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      select_q <= select_d;
    end
  end

  // Reset masks the outputs immediately so an in-flight transfer never acks.
  assign busy      = (state_q == ST_BUSY) && !reset;
  assign out_valid = busy;
  assign select    = reset ? '0 : select_q;
  assign grant     = busy ? idx_to_onehot(select_q) : '0;
  assign ack       = (busy && out_ready) ? idx_to_onehot(select_q) : '0;

  mux_4 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .out   (out_data),
    .select(select),
    .in0   (in0),
    .in1   (in1),
    .in2   (in2),
    .in3   (in3)
  );

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb/tb_rr_arbiter_4.sv - scoreboard bench for rr_arbiter_4
module tb_rr_arbiter_4;

  localparam int W = 32;

  typedef struct {
    int          idx;
    logic [W-1:0] data;
    int          cyc;
  } xfer_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [W-1:0] din[4];
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic [1:0]   select;
  logic [3:0]   grant;
  logic [3:0]   ack;

  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc      = 0;
  bit    started  = 1'b0;
  xfer_t sb_q[$];

  // Reference: which requester holds the bus, and where the next search starts.
  bit m_busy = 1'b0;
  int m_who  = 0;
  int m_ptr  = 0;

  always #5 clk = ~clk;

  rr_arbiter_4 #(.WIDTH(W)) dut (
    .clock    (clk),
    .reset    (reset),
    .req      (req),
    .in0      (din[0]),
    .in1      (din[1]),
    .in2      (din[2]),
    .in3      (din[3]),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .select   (select),
    .grant    (grant),
    .ack      (ack)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model: per-cycle expectations plus completed transfers into the scoreboard.
  always @(negedge clk) begin
    if (started) begin
      cyc++;
      if (reset) begin
        check("valid_rst", out_valid, 0);
        check("grant_rst", grant, 0);
        check("select_rst", select, 0);
        check("data_rst", out_data, din[0]);
        m_busy = 1'b0;
        m_ptr  = 0;
        m_who  = 0;
      end else begin
        check("valid", out_valid, m_busy);
        check("grant", grant, m_busy ? (64'd1 << m_who) : 64'd0);
        if (m_busy) begin
          check("select", select, m_who);
          check("data", out_data, din[m_who]);
          if (out_ready) begin
            sb_q.push_back('{idx: m_who, data: din[m_who], cyc: cyc});
            m_ptr  = (m_who + 1) % 4;
            m_busy = 1'b0;
          end else if (!req[m_who]) begin
            m_busy = 1'b0;
          end
        end else if (req != 4'b0000) begin
          for (int k = 0; k < 4; k++) begin
            if (!m_busy && req[(m_ptr + k) % 4]) begin
              m_who  = (m_ptr + k) % 4;
              m_busy = 1'b1;
            end
          end
        end
      end
    end
  end

  // Monitor: matches every ack pulse against the oldest expected completion.
  always @(negedge clk) begin
    if (started) begin
      #1;
      if (ack != 4'b0000) begin
        if (sb_q.size() == 0) begin
          check("unexpected_ack", ack, 0);
        end else begin
          xfer_t e;
          e = sb_q.pop_front();
          check("ack", ack, 64'd1 << e.idx);
          check("ack_data", out_data, e.data);
        end
      end else begin
        while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
          check("missing_ack", ack, 64'd1 << sb_q[0].idx);
          void'(sb_q.pop_front());
        end
      end
    end
  end

  task automatic drive(input bit rst, input logic [3:0] r, input bit rdy);
    @(posedge clk);
    #1;
    reset     = rst;
    req       = r;
    out_ready = rdy;
  endtask

  initial begin
    reset     = 1'b1;
    req       = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) din[i] = W'(i);
    @(posedge clk);
    #1;
    started = 1'b1;

    // Reset held with all requests pending.
    repeat (3) drive(1'b1, 4'b1111, 1'b1);
    // Full rotation from ptr 0.
    repeat (10) drive(1'b0, 4'b1111, 1'b1);
    // Back-pressured single requester.
    repeat (2) drive(1'b0, 4'b0000, 1'b1);
    repeat (6) drive(1'b0, 4'b0100, 1'b0);
    drive(1'b0, 4'b0100, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    // Wrap from ptr 3.
    repeat (2) drive(1'b0, 4'b0011, 1'b1);
    drive(1'b0, 4'b0000, 1'b1);
    // Abort and re-grant.
    repeat (2) drive(1'b0, 4'b0010, 1'b0);
    drive(1'b0, 4'b0000, 1'b0);
    repeat (2) drive(1'b0, 4'b0010, 1'b1);
    // Reset mid-transfer with consumer ready.
    drive(1'b0, 4'b0000, 1'b1);
    drive(1'b0, 4'b1111, 1'b1);
    drive(1'b1, 4'b1111, 1'b1);
    repeat (2) drive(1'b0, 4'b0000, 1'b1);

    // Random traffic: a requester keeps its data stable while its request is up.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] r;
      r = req;
      for (int i = 0; i < 4; i++) begin
        if (r[i]) begin
          if ($urandom_range(7) == 0) r[i] = 1'b0;
        end else begin
          din[i] = $urandom;
          if ($urandom_range(2) == 0) r[i] = 1'b1;
        end
      end
      drive($urandom_range(60) == 0, r, $urandom_range(1) == 1);
    end

    repeat (3) drive(1'b0, 4'b0000, 1'b1);
    @(negedge clk);
    #2;
    check("scoreboard_empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
